packed_align_shifter_pipe: RTL and testbench
============================================

Name: packed_align_shifter_pipe

Overview:
- Pipelined right-shift alignment unit for the shared FP adder datapath.
- Runs one of two modes per transaction: one wide lane (FP32 mantissa) or N_LANES independent sub-lanes (packed FP16).
- Each lane produces its own sticky bit.
- Uses valid/ready handshakes and a configurable number of register stages, so it can be placed between the exponent-difference and add stages at full throughput.

Parameters:
- LANE_W, 13, bit width of one sub-lane; total width TW = N_LANES*LANE_W.
- N_LANES, 2, number of sub-lanes; power of 2, 2..4.
- SH_W, 4, per-lane shift-amount width; wide-mode shift width WSH_W = clog2(TW)+1, and WSH_W <= N_LANES*SH_W must hold.
- PIPE_STAGES, 2, number of register stages; range 1..5. The shift steps (powers of two) are split evenly, with earlier stages taking the remainder.
- TAG_W, 4, width of the user tag passed through alongside the data.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  input transaction valid
- in_ready  out  1  block can accept an input this cycle
- in_fmt  in  1  0 = wide single lane, 1 = split into N_LANES
- in_data  in  TW  operand; lane i occupies bits [i*LANE_W +: LANE_W]
- in_shamt  in  N_LANES*SH_W  split mode: lane i amount is [i*SH_W +: SH_W]; wide mode: amount is [WSH_W-1:0]
- in_tag  in  TAG_W  user tag
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out_data  out  TW  shifted result
- out_sticky  out  N_LANES  per-lane sticky; in wide mode only bit 0 is used and the rest are 0
- out_fmt  out  1  in_fmt of this result
- out_tag  out  TAG_W  in_tag of this result

Behaviour:
- Reset: synchronous, active-high. Every stage valid bit clears to 0.
  - After reset: out_valid=0, out_data=0, out_sticky=0, out_fmt=0, out_tag=0, in_ready=1.
  - Asserting rst mid-operation discards all in-flight transactions. On the cycle after rst, out_valid=0.
- Transfer: an input is accepted when in_valid && in_ready; an output is consumed when out_valid && out_ready.
- Latency and throughput:
  - Latency is exactly PIPE_STAGES cycles from acceptance to out_valid, when there is no backpressure.
  - Throughput is 1 transaction per cycle.
- Stage advance rule: stage k loads when it is empty or when stage k+1 loads (the last stage uses out_ready).
  - in_ready = stage 0 is empty or stage 0 advances. This is combinational from out_ready through the chain; there is no skid buffer.
- Stalls: while a result is stalled (out_valid && !out_ready), out_data, out_sticky, out_fmt and out_tag hold stable.
  - Transactions never drop, duplicate or reorder.
- Wide mode: logical right shift of in_data by amount s.
  - If s >= TW: out_data = 0 and sticky = |in_data.
  - Otherwise sticky = OR of the s bits shifted out.
  - Bits cross lane boundaries.
- Split mode: each lane is shifted independently by its own s_i. No bit crosses a lane boundary; zeros enter at each lane MSB.
  - If s_i >= LANE_W: the lane output is 0 and sticky_i = OR of the lane.
- Sticky accumulation: sticky accumulates stage-by-stage and is carried in the pipeline registers. It must equal the combinational definition above.
- Simultaneous events: acceptance and emission in the same cycle is legal and leaves occupancy unchanged. rst has priority over any transfer.
- Mode per transaction: the mode may change every transaction. Mixing fmt values back-to-back causes no bubble.

Optional Feature:
- Macro: SHIFTER_PERF_CNT_EN.
- Defined:
  - Adds output port perf_sticky_cnt, 16 bits.
  - Increments by 1 on each output handshake where any out_sticky bit is 1.
  - Saturates at 16'hFFFF and clears on rst.
- Undefined: the port and the counter logic are absent. Datapath behaviour is identical in both cases.

Test Plan:
- Wide shift: fmt=0, data=26'h2000001, shamt=8'h01 -> after 2 cycles out_data=26'h1000000, out_sticky=2'b01.
- Split shift: fmt=1, data=26'h2000003 (lane1=13'h1000, lane0=13'h0003), shamt=8'h41 -> out_data=26'h0200001 (lane1=13'h0100, lane0=13'h0001), out_sticky=2'b01.
- Saturation:
  - fmt=0, data=26'h0000001, shamt=8'h1A -> out_data=0, sticky=2'b01.
  - fmt=1, data=26'h0020000, shamt=8'hF0 -> out_data=0, sticky=2'b10.
- Backpressure: push 4 back-to-back with out_ready=0 -> in_ready falls after 2 accepts; outputs stay stable. Raise out_ready -> all 4 emerge in order with correct tags 0..3.
- Reset mid-flight: 2 transactions in flight, pulse rst for 1 cycle -> out_valid=0 next cycle, in_ready=1, no stale result ever appears.
- With SHIFTER_PERF_CNT_EN: stream of 5 results, 3 of them sticky -> perf_sticky_cnt=3. Preload near saturation -> counter holds at 16'hFFFF.

Source files
------------

// File: rtl/packed_align_shifter_pipe.sv
// Pipelined right-shift aligner: one wide lane or N_LANES packed sub-lanes, per-lane sticky.
// Optional SHIFTER_PERF_CNT_EN adds a saturating count of sticky results (perf_sticky_cnt).
module packed_align_shifter_pipe #(
  parameter int LANE_W      = 13,
  parameter int N_LANES     = 2,
  parameter int SH_W        = 4,
  parameter int PIPE_STAGES = 2,
  parameter int TAG_W       = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_fmt,
  input  logic [N_LANES*LANE_W-1:0] in_data,
  input  logic [N_LANES*SH_W-1:0]   in_shamt,
  input  logic [TAG_W-1:0]          in_tag,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N_LANES*LANE_W-1:0] out_data,
  output logic [N_LANES-1:0]        out_sticky,
  output logic                      out_fmt,
  output logic [TAG_W-1:0]          out_tag
`ifdef SHIFTER_PERF_CNT_EN
  ,
  output logic [15:0]               perf_sticky_cnt
`endif
);

  localparam int TW    = N_LANES * LANE_W;
  localparam int WSH_W = $clog2(TW) + 1;
  localparam int SHT_W = N_LANES * SH_W;
  localparam int NSTEP = (WSH_W > SH_W) ? WSH_W : SH_W;
  localparam int BASE  = NSTEP / PIPE_STAGES;
  localparam int REM   = NSTEP % PIPE_STAGES;
  localparam logic [TW-1:0]     ONES_TW = {TW{1'b1}};
  localparam logic [LANE_W-1:0] ONES_L  = {LANE_W{1'b1}};

  // First shift step handled by stage s; earlier stages absorb the remainder.
  function automatic int stage_lo(input int s);
    return s * BASE + ((s < REM) ? s : REM);
  endfunction

  // Apply shift steps [lo, hi) and fold the lost bits into the sticky vector.
  function automatic logic [N_LANES+TW-1:0] f_shift(
    input logic [TW-1:0]      d,
    input logic [N_LANES-1:0] st,
    input logic               fmt,
    input logic [SHT_W-1:0]   sh,
    input int                 lo,
    input int                 hi
  );
    logic [TW-1:0]      v_d;
    logic [N_LANES-1:0] v_st;
    logic [LANE_W-1:0]  v_lane;
    logic [NSTEP-1:0]   v_wx;
    logic [NSTEP-1:0]   v_lx;
    v_d    = d;
    v_st   = st;
    v_lane = '0;
    v_wx   = NSTEP'(sh[WSH_W-1:0]);
    v_lx   = '0;
    for (int k = 0; k < NSTEP; k++) begin
      if (k >= lo && k < hi) begin
        if (!fmt) begin
          if (v_wx[k]) begin
            v_st[0] = v_st[0] | (|(v_d & ~(ONES_TW << (1 << k))));
            v_d     = v_d >> (1 << k);
          end
        end else begin
          for (int i = 0; i < N_LANES; i++) begin
            v_lx = NSTEP'(sh[i*SH_W +: SH_W]);
            if (v_lx[k]) begin
              v_lane  = v_d[i*LANE_W +: LANE_W];
              v_st[i] = v_st[i] | (|(v_lane & ~(ONES_L << (1 << k))));
              v_d[i*LANE_W +: LANE_W] = v_lane >> (1 << k);
            end
          end
        end
      end
    end
    return {v_st, v_d};
  endfunction

  logic [PIPE_STAGES-1:0] r_valid;
  logic [TW-1:0]          r_data   [PIPE_STAGES];
  logic [N_LANES-1:0]     r_sticky [PIPE_STAGES];
  logic                   r_fmt    [PIPE_STAGES];
  logic [SHT_W-1:0]       r_shamt  [PIPE_STAGES];
  logic [TAG_W-1:0]       r_tag    [PIPE_STAGES];

  logic [PIPE_STAGES-1:0] w_load;
  logic [N_LANES+TW-1:0]  w_nxt [PIPE_STAGES];

  // Load enables ripple back from out_ready; no skid buffering.
  always_comb begin
    logic v_l;
    w_load = '0;
    v_l = !r_valid[PIPE_STAGES-1] || out_ready;
    w_load[PIPE_STAGES-1] = v_l;
    for (int s = PIPE_STAGES - 2; s >= 0; s--) begin
      v_l = !r_valid[s] || v_l;
      w_load[s] = v_l;
    end
  end

  always_comb begin
    for (int s = 0; s < PIPE_STAGES; s++) w_nxt[s] = '0;
    w_nxt[0] = f_shift(in_data, '0, in_fmt, in_shamt, stage_lo(0), stage_lo(1));
    for (int s = 1; s < PIPE_STAGES; s++) begin
      w_nxt[s] = f_shift(r_data[s-1], r_sticky[s-1], r_fmt[s-1], r_shamt[s-1],
                         stage_lo(s), stage_lo(s + 1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      for (int s = 0; s < PIPE_STAGES; s++) begin
        r_data[s]   <= '0;
        r_sticky[s] <= '0;
        r_fmt[s]    <= 1'b0;
        r_shamt[s]  <= '0;
        r_tag[s]    <= '0;
      end
    end else begin
      if (w_load[0]) begin
        r_valid[0] <= in_valid;
        if (in_valid) begin
          r_data[0]   <= w_nxt[0][TW-1:0];
          r_sticky[0] <= w_nxt[0][TW +: N_LANES];
          r_fmt[0]    <= in_fmt;
          r_shamt[0]  <= in_shamt;
          r_tag[0]    <= in_tag;
        end
      end
      for (int s = 1; s < PIPE_STAGES; s++) begin
        if (w_load[s]) begin
          r_valid[s] <= r_valid[s-1];
          if (r_valid[s-1]) begin
            r_data[s]   <= w_nxt[s][TW-1:0];
            r_sticky[s] <= w_nxt[s][TW +: N_LANES];
            r_fmt[s]    <= r_fmt[s-1];
            r_shamt[s]  <= r_shamt[s-1];
            r_tag[s]    <= r_tag[s-1];
          end
        end
      end
    end
  end

  assign in_ready   = w_load[0];
  assign out_valid  = r_valid[PIPE_STAGES-1];
  assign out_data   = r_data[PIPE_STAGES-1];
  assign out_sticky = r_sticky[PIPE_STAGES-1];
  assign out_fmt    = r_fmt[PIPE_STAGES-1];
  assign out_tag    = r_tag[PIPE_STAGES-1];

`ifdef SHIFTER_PERF_CNT_EN
  logic [15:0] r_perf_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_cnt <= '0;
    end else if (out_valid && out_ready && (|out_sticky) && (r_perf_cnt != 16'hFFFF)) begin
      r_perf_cnt <= r_perf_cnt + 16'd1;
    end
  end

  assign perf_sticky_cnt = r_perf_cnt;
`else
  // No sticky-result counter in this build.
`endif

endmodule

// File: tb/tb_packed_align_shifter_pipe.sv
// Self-checking bench for packed_align_shifter_pipe: directed, backpressure, reset and random traffic.
module tb_packed_align_shifter_pipe;

  localparam int TW = 26;
  localparam int LW = 13;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic          in_fmt;
  logic [25:0]   in_data;
  logic [7:0]    in_shamt;
  logic [3:0]    in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [25:0]   out_data;
  logic [1:0]    out_sticky;
  logic          out_fmt;
  logic [3:0]    out_tag;
`ifdef SHIFTER_PERF_CNT_EN
  logic [15:0]   perf_sticky_cnt;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [25:0] d;
    logic [1:0]  s;
    logic        f;
    logic [3:0]  t;
  } exp_t;

  exp_t q[$];

  packed_align_shifter_pipe dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_fmt     (in_fmt),
    .in_data    (in_data),
    .in_shamt   (in_shamt),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_sticky (out_sticky),
    .out_fmt    (out_fmt),
    .out_tag    (out_tag)
`ifdef SHIFTER_PERF_CNT_EN
    ,
    .perf_sticky_cnt (perf_sticky_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain arithmetic on the shift definition, lost bits via modulo.
  function automatic void model(input logic f, input logic [25:0] d, input logic [7:0] sh,
                                output logic [25:0] od, output logic [1:0] os);
    longint unsigned dv;
    longint unsigned lv;
    int s;
    od = '0;
    os = '0;
    if (!f) begin
      s  = int'(sh[5:0]);
      dv = 64'(d);
      if (s >= TW) begin
        os[0] = (dv != 0);
      end else begin
        od    = 26'(dv >> s);
        os[0] = ((dv % (64'd1 << s)) != 0);
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        s  = int'(sh[i*4 +: 4]);
        lv = 64'(d[i*LW +: LW]);
        if (s >= LW) begin
          os[i] = (lv != 0);
        end else begin
          od[i*LW +: LW] = 13'(lv >> s);
          os[i] = ((lv % (64'd1 << s)) != 0);
        end
      end
    end
  endfunction

  function automatic exp_t expect_cur();
    exp_t e;
    model(in_fmt, in_data, in_shamt, e.d, e.s);
    e.f = in_fmt;
    e.t = in_tag;
    return e;
  endfunction

  task automatic test_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== 26'h0) begin errors++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    checks++; if (out_sticky !== 2'b00) begin errors++; $display("FAIL reset_out_sticky: got %b want 00", out_sticky); end
    checks++; if (out_fmt !== 1'b0) begin errors++; $display("FAIL reset_out_fmt: got %b want 0", out_fmt); end
    checks++; if (out_tag !== 4'h0) begin errors++; $display("FAIL reset_out_tag: got %h want 0", out_tag); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_directed();
    logic        t_f  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [25:0] t_d  [4] = '{26'h2000001, 26'h2000003, 26'h0000001, 26'h0020000};
    logic [7:0]  t_sh [4] = '{8'h01, 8'h41, 8'h1A, 8'hF0};
    logic [25:0] t_ed [4] = '{26'h1000000, 26'h0200001, 26'h0, 26'h0};
    logic [1:0]  t_es [4] = '{2'b01, 2'b01, 2'b01, 2'b10};
    int lat;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_fmt = t_f[i]; in_data = t_d[i]; in_shamt = t_sh[i];
      in_tag = 4'(i + 5); out_ready = 1'b1;
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL dir_in_ready[%0d]: got %b want 1", i, in_ready); end
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (lat <= 10) begin
        @(negedge clk);
        if (out_valid) break;
        @(posedge clk); #1;
        lat++;
      end
      checks++; if (lat !== 2) begin errors++; $display("FAIL dir_latency[%0d]: got %0d want 2", i, lat); end
      checks++; if (out_data !== t_ed[i]) begin errors++; $display("FAIL dir_data[%0d]: got %h want %h", i, out_data, t_ed[i]); end
      checks++; if (out_sticky !== t_es[i]) begin errors++; $display("FAIL dir_sticky[%0d]: got %b want %b", i, out_sticky, t_es[i]); end
      checks++; if (out_fmt !== t_f[i]) begin errors++; $display("FAIL dir_fmt[%0d]: got %b want %b", i, out_fmt, t_f[i]); end
      checks++; if (out_tag !== 4'(i + 5)) begin errors++; $display("FAIL dir_tag[%0d]: got %h want %h", i, out_tag, 4'(i + 5)); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    int acc;
    int got;
    exp_t e;
    logic [25:0] h_d;
    logic [1:0]  h_s;
    logic [3:0]  h_t;
    acc = 0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int c = 0; c < 4; c++) begin
      in_fmt = 1'($urandom); in_data = 26'($urandom); in_shamt = 8'($urandom); in_tag = 4'(acc);
      @(negedge clk);
      if (in_valid && in_ready) begin q.push_back(expect_cur()); acc++; end
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++; if (acc !== 2) begin errors++; $display("FAIL bp_accepts_before_stall: got %0d want 2", acc); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_low: got %b want 0", in_ready); end
    h_d = out_data; h_s = out_sticky; h_t = out_tag;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== h_d || out_sticky !== h_s || out_tag !== h_t) begin
        errors++;
        $display("FAIL bp_stall_stable: got v=%b d=%h s=%b t=%h want v=1 d=%h s=%b t=%h",
                 out_valid, out_data, out_sticky, out_tag, h_d, h_s, h_t);
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 30 && got < 4; c++) begin
      if (acc < 4) begin
        in_valid = 1'b1; in_fmt = 1'($urandom); in_data = 26'($urandom);
        in_shamt = 8'($urandom); in_tag = 4'(acc);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (out_valid && out_ready) begin
        e = q.pop_front();
        checks++; if (out_tag !== 4'(got)) begin errors++; $display("FAIL bp_order_tag: got %h want %h", out_tag, 4'(got)); end
        checks++; if (out_data !== e.d || out_sticky !== e.s) begin
          errors++; $display("FAIL bp_data: got %h/%b want %h/%b", out_data, out_sticky, e.d, e.s);
        end
        got++;
      end
      if (in_valid && in_ready) begin q.push_back(expect_cur()); acc++; end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checks++; if (got !== 4) begin errors++; $display("FAIL bp_drain_count: got %0d want 4", got); end
  endtask

  task automatic test_reset_midflight();
    int stale;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int c = 0; c < 2; c++) begin
      in_fmt = 1'($urandom); in_data = 26'($urandom); in_shamt = 8'($urandom); in_tag = 4'(c + 9);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_inflight: got %b want 1", out_valid); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready: got %b want 1", in_ready); end
    q.delete();
    out_ready = 1'b1;
    stale = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (out_valid) stale++;
    end
    checks++; if (stale !== 0) begin errors++; $display("FAIL rstmid_stale: got %0d stale results want 0", stale); end
  endtask

  task automatic test_random();
    exp_t e;
    logic        p_stall;
    logic [25:0] p_d;
    logic [1:0]  p_s;
    logic        p_f;
    logic [3:0]  p_t;
    int n_out;
    p_stall = 1'b0; p_d = '0; p_s = '0; p_f = 1'b0; p_t = '0;
    n_out = 0;
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_fmt    = 1'($urandom);
      in_data   = 26'($urandom);
      if ($urandom_range(0, 1) == 1) in_data = in_data & 26'($urandom) & 26'($urandom);
      in_shamt  = 8'($urandom);
      if ($urandom_range(0, 1) == 1) in_shamt = in_shamt & 8'h33;
      in_tag    = 4'($urandom);
      @(negedge clk);
      if (p_stall) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== p_d || out_sticky !== p_s || out_fmt !== p_f || out_tag !== p_t) begin
          errors++;
          $display("FAIL rand_stall_stable: got v=%b d=%h s=%b t=%h want v=1 d=%h s=%b t=%h",
                   out_valid, out_data, out_sticky, out_tag, p_d, p_s, p_t);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL rand_unexpected_output: got tag %h want none", out_tag);
        end else begin
          e = q.pop_front();
          if (out_data !== e.d || out_sticky !== e.s || out_fmt !== e.f || out_tag !== e.t) begin
            errors++;
            $display("FAIL rand_result: got d=%h s=%b f=%b t=%h want d=%h s=%b f=%b t=%h",
                     out_data, out_sticky, out_fmt, out_tag, e.d, e.s, e.f, e.t);
          end
        end
        n_out++;
      end
      if (in_valid && in_ready) q.push_back(expect_cur());
      p_stall = out_valid && !out_ready;
      p_d = out_data; p_s = out_sticky; p_f = out_fmt; p_t = out_tag;
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL rand_drain_unexpected: got tag %h want none", out_tag);
        end else begin
          e = q.pop_front();
          if (out_data !== e.d || out_sticky !== e.s || out_fmt !== e.f || out_tag !== e.t) begin
            errors++;
            $display("FAIL rand_drain_result: got d=%h s=%b t=%h want d=%h s=%b t=%h",
                     out_data, out_sticky, out_tag, e.d, e.s, e.t);
          end
        end
      end
      @(posedge clk); #1;
    end
    checks++; if (q.size() !== 0) begin errors++; $display("FAIL rand_lost: got %0d pending want 0", q.size()); end
    checks++; if (n_out < 50) begin errors++; $display("FAIL rand_throughput: got %0d outputs want >=50", n_out); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int got;
    int cyc;
    out_ready = 1'b1;
    got = 0;
    cyc = 0;
    for (int c = 0; c < 8; c++) begin
      in_valid = 1'b1; in_fmt = c[0]; in_data = 26'($urandom); in_shamt = 8'($urandom); in_tag = 4'(c);
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready[%0d]: got %b want 1", c, in_ready); end
      q.push_back(expect_cur());
      if (out_valid) begin
        e = q.pop_front();
        if (out_data !== e.d || out_sticky !== e.s || out_fmt !== e.f || out_tag !== e.t) begin
          errors++; $display("FAIL b2b_result: got d=%h t=%h want d=%h t=%h", out_data, out_tag, e.d, e.t);
        end
        got++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    while (q.size() != 0 && cyc < 10) begin
      @(negedge clk);
      if (out_valid) begin
        e = q.pop_front();
        if (out_data !== e.d || out_sticky !== e.s || out_fmt !== e.f || out_tag !== e.t) begin
          errors++; $display("FAIL b2b_result: got d=%h t=%h want d=%h t=%h", out_data, out_tag, e.d, e.t);
        end
        got++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    checks++; if (got !== 8) begin errors++; $display("FAIL b2b_count: got %0d want 8", got); end
  endtask

`ifdef SHIFTER_PERF_CNT_EN
  task automatic test_perf_cnt();
    logic [15:0] base;
    logic [25:0] t_d [5] = '{26'h1, 26'h2, 26'h3, 26'h4, 26'h5};
    base = perf_sticky_cnt;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; in_fmt = 1'b0; in_data = t_d[c]; in_shamt = 8'h01; in_tag = 4'(c);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (perf_sticky_cnt - base !== 16'd3) begin
      errors++; $display("FAIL perf_cnt: got %0d want 3", perf_sticky_cnt - base);
    end
  endtask
`endif

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_fmt = 1'b0; in_data = '0; in_shamt = '0; in_tag = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    @(posedge clk); #1;
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    test_random();
`ifdef SHIFTER_PERF_CNT_EN
    test_perf_cnt();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
